// File: rtl/store_merge_unit.sv
// ============================================================================
// store_merge_unit
// ----------------------------------------------------------------------------
// Turns byte, halfword and word store requests into full-word memory writes.
// Word stores are written directly. Byte and halfword stores read the target
// word, merge the new data into the addressed big-endian lane and write the
// merged word back. Reserved-size requests complete without memory access.
//
// Optional feature (macro STORE_ALIGN_CHECK_EN):
//   When defined, a halfword with addr[0]=1 or a word with addr[1:0]!=00
//   completes immediately with misalign=1 and performs no memory access.
//   When undefined, misalign is tied to 0 and the low address bits are
//   ignored for those sizes.
//
// Ports:
//   clk        in   1   clock, all state changes on rising edge
//   reset      in   1   synchronous active-high reset
//   st_valid   in   1   store request present
//   st_ready   out  1   request accepted this cycle when st_valid is high
//   st_size    in   2   00 byte, 01 half, 10 word, 11 reserved
//   st_addr    in  32   byte address
//   st_data    in  32   right-justified store data
//   mem_addr   out 30   word address of the latched request
//   mem_rd_en  out  1   word read strobe
//   mem_rdata  in  32   read data, valid the cycle after mem_rd_en
//   mem_wr_en  out  1   full-word write strobe
//   mem_wdata  out 32   word to write
//   done       out  1   one-cycle completion pulse
//   misalign   out  1   alignment fault, qualified by done
// ============================================================================
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic [29:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        misalign
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic [31:0] wdata_q;
    logic        accept;
    logic        bad_align;

`ifdef STORE_ALIGN_CHECK_EN
    logic        mis_q;
`endif

    // ------------------------------------------------------------------------
    // Lane merge: big-endian, byte offset 0 lands in bits [31:24].
    // ------------------------------------------------------------------------
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [1:0]  offset,
        input logic [1:0]  size,
        input logic [31:0] data
    );
        logic [31:0] w;
        w = old_word;
        if (size == SIZE_BYTE) begin
            case (offset)
                2'd0:    w[31:24] = data[7:0];
                2'd1:    w[23:16] = data[7:0];
                2'd2:    w[15:8]  = data[7:0];
                default: w[7:0]   = data[7:0];
            endcase
        end else begin
            if (offset[1] == 1'b0) begin
                w[31:16] = data[15:0];
            end else begin
                w[15:0]  = data[15:0];
            end
        end
        return w;
    endfunction

    assign accept = st_valid && st_ready;

`ifdef STORE_ALIGN_CHECK_EN
    assign bad_align = ((st_size == SIZE_HALF) && st_addr[0]) ||
                       ((st_size == SIZE_WORD) && (st_addr[1:0] != 2'b00));
`else
    assign bad_align = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= st_addr;
                size_q  <= st_size;
                data_q  <= st_data;
                // Word stores write the request data as-is; sub-word
                // stores overwrite this with the merged word in WAIT.
                wdata_q <= st_data;
`ifdef STORE_ALIGN_CHECK_EN
                mis_q   <= bad_align;
`endif
            end
            if (state == WAIT) begin
                wdata_q <= merge_word(mem_rdata, addr_q[1:0], size_q, data_q);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs. All outputs are forced low while reset is high
    // so a request in flight never produces a strobe on the reset cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        st_ready   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if ((st_size == SIZE_RSVD) || bad_align) begin
                        state_next = FIN;
                    end else if (st_size == SIZE_WORD) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = WAIT;
            WAIT:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (!reset) begin
            st_ready  = (state == IDLE);
            mem_rd_en = (state == READ);
            mem_wr_en = (state == WRITE);
            done      = (state == WRITE) || (state == FIN);
            mem_addr  = addr_q[31:2];
            mem_wdata = wdata_q;
`ifdef STORE_ALIGN_CHECK_EN
            misalign  = (state == FIN) && mis_q;
`endif
        end
    end

endmodule
